exp4_trena_top: RTL and testbench

// - Ultrasonic "tape measure" for an HC-SR04-style sensor.
// - Each request issues a 10 us trigger pulse, times the echo pulse and converts the width to centimetres.
// - The result is shown as 3 BCD digits on 7-segment outputs and sent over UART as 4 ASCII characters "DDD#".
// - Top-level block of the lab design; all ports go to board pins.

---
 rtl/trena_pkg.sv | 72 +++++++
 rtl/exp4_trena_top_uart_tx_7o2.sv | 80 ++++++++
 rtl/exp4_trena_top.sv | 219 +++++++++++++++++++++
 tb/tb_exp4_trena_top.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/trena_pkg.sv
// Shared definitions for the ultrasonic tape measure: clock-derived timing
// defaults, FSM state codes, ASCII constants, and the BCD and 7-segment helpers.
package trena_pkg;

    localparam int CLK_HZ          = 50_000_000;
    localparam int TRIG_CYC_DEF    = CLK_HZ / 100_000;      // 10 us
    localparam int CYC_PER_CM_DEF  = 2941;                  // 58.82 us per cm
    localparam int BAUD_CYC_DEF    = CLK_HZ / 115_200;      // 434 clocks per bit
    localparam int TIMEOUT_CYC_DEF = (CLK_HZ / 1000) * 30;  // 30 ms

    localparam logic [6:0]  ASCII_ZERO = 7'h30;
    localparam logic [6:0]  ASCII_HASH = 7'h23;
    localparam logic [11:0] BCD_MAX    = 12'h999;

    // The enum values are the codes shown on the state display.
    typedef enum logic [3:0] {
        ST_INICIAL     = 4'h0,
        ST_PREPARA     = 4'h1,
        ST_TRIGGER     = 4'h2,
        ST_ESPERA_ECHO = 4'h3,
        ST_MEDE        = 4'h4,
        ST_ARMAZENA    = 4'h5,
        ST_TRANSMITE   = 4'h6,
        ST_ESPERA_TX   = 4'h7,
        ST_FINAL       = 4'hF
    } state_t;

    // Hex digit to 7-segment pattern, bit order gfedcba, active-high.
    function automatic logic [6:0] hex7seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Three-digit BCD increment that sticks at 999.
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v != BCD_MAX) begin
            if (v[3:0] != 4'd9) begin
                r[3:0] = v[3:0] + 4'd1;
            end else begin
                r[3:0] = 4'd0;
                if (v[7:4] != 4'd9) begin
                    r[7:4] = v[7:4] + 4'd1;
                end else begin
                    r[7:4]  = 4'd0;
                    r[11:8] = v[11:8] + 4'd1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/exp4_trena_top_uart_tx_7o2.sv
// UART transmitter, 7 data bits LSB first, odd parity, 2 stop bits.
// pronto_tx pulses for one clock when the second stop bit has finished.
module uart_tx_7o2
    import trena_pkg::*;
#(
    parameter int BAUD_CYC = BAUD_CYC_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       partida,
    input  logic [6:0] dados,
    output logic       saida_serial,
    output logic       pronto_tx
);

    localparam int BW = $clog2(BAUD_CYC + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_CYC - 1);

    logic          busy_q, busy_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [3:0]    left_q, left_d;
    logic [9:0]    shreg_q, shreg_d;
    logic          tx_q, tx_d;
    logic          done_q, done_d;

    // Start bit goes out directly; the remaining ten bits wait in the shift register.
    always_comb begin
        busy_d  = busy_q;
        baud_d  = baud_q;
        left_d  = left_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        if (!busy_q) begin
            if (partida) begin
                busy_d  = 1'b1;
                tx_d    = 1'b0;
                shreg_d = {2'b11, ~^dados, dados};
                left_d  = 4'd10;
                baud_d  = '0;
            end
        end else if (baud_q == BAUD_LAST) begin
            baud_d = '0;
            if (left_q != 4'd0) begin
                tx_d    = shreg_q[0];
                shreg_d = {1'b1, shreg_q[9:1]};
                left_d  = left_q - 4'd1;
            end else begin
                busy_d = 1'b0;
                done_d = 1'b1;
                tx_d   = 1'b1;
            end
        end else begin
            baud_d = baud_q + BW'(1);
        end
    end

    // Transmitter state registers; the line idles high.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_q  <= 1'b0;
            baud_q  <= '0;
            left_q  <= 4'd0;
            shreg_q <= '1;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            baud_q  <= baud_d;
            left_q  <= left_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign saida_serial = tx_q;
    assign pronto_tx    = done_q;

endmodule

// File: rtl/exp4_trena_top.sv
// Ultrasonic tape measure: trigger pulse, echo timing in cm (BCD, rounded,
// saturating at 999), 7-segment display and "DDD#" over UART.
// Optional echo watchdog enabled by defining TIMEOUT_EN.
module exp4_trena_top
    import trena_pkg::*;
#(
    parameter int TRIG_CYC   = TRIG_CYC_DEF,
    parameter int CYC_PER_CM = CYC_PER_CM_DEF,
    parameter int BAUD_CYC   = BAUD_CYC_DEF
`ifdef TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       mensurar,
    input  logic       echo,
    output logic       trigger,
    output logic       saida_serial,
    output logic [6:0] medida0,
    output logic [6:0] medida1,
    output logic [6:0] medida2,
    output logic       pronto,
    output logic [6:0] db_estado
);

    localparam int TGW = $clog2(TRIG_CYC + 1);
    localparam int TKW = $clog2(CYC_PER_CM + 1);
    localparam logic [TGW-1:0] TRIG_LAST = TGW'(TRIG_CYC - 1);
    localparam logic [TKW-1:0] TICK_LAST = TKW'(CYC_PER_CM - 1);
    localparam logic [TKW-1:0] TICK_HALF = TKW'(CYC_PER_CM / 2);

    state_t         state_q;
    logic           trigger_q, pronto_q;
    logic [TGW-1:0] trig_cnt_q;
    logic [TKW-1:0] tick_q, tick_step;
    logic [11:0]    bcd_q, bcd_step, disp_q;
    logic [1:0]     char_idx_q;
    logic [2:0]     mens_q, mens_d;
    logic [1:0]     echo_q, echo_d;
    logic           start_edge, echo_s, timeout_hit, tx_done;
    logic [6:0]     tx_char;
    logic [6:0]     seg_w [3];

    // Two-flop synchronisers; mensurar gets a third stage for edge detection.
    always_comb begin
        mens_d = {mens_q[1:0], mensurar};
        echo_d = {echo_q[0], echo};
    end

    // Synchroniser registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mens_q <= '0;
            echo_q <= '0;
        end else begin
            mens_q <= mens_d;
            echo_q <= echo_d;
        end
    end

    assign start_edge = mens_q[1] & ~mens_q[2];
    assign echo_s     = echo_q[1];

    // One echo clock: tick wraps at CYC_PER_CM and then bumps the BCD count.
    always_comb begin
        if (tick_q == TICK_LAST) begin
            tick_step = '0;
            bcd_step  = bcd_inc(bcd_q);
        end else begin
            tick_step = tick_q + TKW'(1);
            bcd_step  = bcd_q;
        end
    end

`ifdef TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYC + 1);
    logic [WDW-1:0] wdog_q, wdog_d;
    logic           waiting;

    assign waiting = (state_q == ST_ESPERA_ECHO) || (state_q == ST_MEDE);

    // Watchdog runs only while waiting for or measuring the echo.
    always_comb begin
        wdog_d = waiting ? wdog_q + WDW'(1) : '0;
    end

    // Watchdog register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end

    assign timeout_hit = waiting && (wdog_q == WDW'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Measurement sequencer with registered trigger/pronto and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_INICIAL;
            trigger_q  <= 1'b0;
            pronto_q   <= 1'b0;
            trig_cnt_q <= '0;
            tick_q     <= '0;
            bcd_q      <= '0;
            disp_q     <= '0;
            char_idx_q <= 2'd0;
        end else begin
            case (state_q)
                ST_INICIAL: begin
                    if (start_edge) state_q <= ST_PREPARA;
                end
                ST_PREPARA: begin
                    trig_cnt_q <= '0;
                    tick_q     <= '0;
                    bcd_q      <= '0;
                    trigger_q  <= 1'b1;
                    state_q    <= ST_TRIGGER;
                end
                ST_TRIGGER: begin
                    if (trig_cnt_q == TRIG_LAST) begin
                        trigger_q <= 1'b0;
                        state_q   <= ST_ESPERA_ECHO;
                    end else begin
                        trig_cnt_q <= trig_cnt_q + TGW'(1);
                    end
                end
                ST_ESPERA_ECHO: begin
                    // The first high echo cycle is already counted here.
                    if (timeout_hit) begin
                        bcd_q   <= BCD_MAX;
                        state_q <= ST_ARMAZENA;
                    end else if (echo_s) begin
                        tick_q  <= tick_step;
                        bcd_q   <= bcd_step;
                        state_q <= ST_MEDE;
                    end
                end
                ST_MEDE: begin
                    if (timeout_hit) begin
                        bcd_q   <= BCD_MAX;
                        state_q <= ST_ARMAZENA;
                    end else if (echo_s) begin
                        tick_q <= tick_step;
                        bcd_q  <= bcd_step;
                    end else begin
                        if (tick_q >= TICK_HALF) bcd_q <= bcd_inc(bcd_q);
                        state_q <= ST_ARMAZENA;
                    end
                end
                ST_ARMAZENA: begin
                    disp_q     <= bcd_q;
                    char_idx_q <= 2'd0;
                    state_q    <= ST_TRANSMITE;
                end
                ST_TRANSMITE: begin
                    state_q <= ST_ESPERA_TX;
                end
                ST_ESPERA_TX: begin
                    if (tx_done) begin
                        if (char_idx_q == 2'd3) begin
                            pronto_q <= 1'b1;
                            state_q  <= ST_FINAL;
                        end else begin
                            char_idx_q <= char_idx_q + 2'd1;
                            state_q    <= ST_TRANSMITE;
                        end
                    end
                end
                ST_FINAL: begin
                    if (start_edge) begin
                        pronto_q <= 1'b0;
                        state_q  <= ST_PREPARA;
                    end
                end
                default: state_q <= ST_INICIAL;
            endcase
        end
    end

    // Character order: hundreds, tens, units, then '#'.
    always_comb begin
        case (char_idx_q)
            2'd0:    tx_char = ASCII_ZERO + {3'b000, disp_q[11:8]};
            2'd1:    tx_char = ASCII_ZERO + {3'b000, disp_q[7:4]};
            2'd2:    tx_char = ASCII_ZERO + {3'b000, disp_q[3:0]};
            default: tx_char = ASCII_HASH;
        endcase
    end

    uart_tx_7o2 #(
        .BAUD_CYC(BAUD_CYC)
    ) u_tx (
        .clock        (clock),
        .reset        (reset),
        .partida      (state_q == ST_TRANSMITE),
        .dados        (tx_char),
        .saida_serial (saida_serial),
        .pronto_tx    (tx_done)
    );

    for (genvar gi = 0; gi < 3; gi++) begin : g_digit
        assign seg_w[gi] = hex7seg(disp_q[4*gi +: 4]);
    end

    assign medida0   = seg_w[0];
    assign medida1   = seg_w[1];
    assign medida2   = seg_w[2];
    assign trigger   = trigger_q;
    assign pronto    = pronto_q;
    assign db_estado = hex7seg(state_q);

endmodule

// File: tb/tb_exp4_trena_top.sv
// Bench for exp4_trena_top with scaled timing (CYC_PER_CM=10, TRIG_CYC=20,
// BAUD_CYC=8). Expected centimetres come from floor(w/C), rounded up when the
// remainder reaches C/2, capped at 999. Also covers TIMEOUT_EN when defined.
module tb_exp4_trena_top;

    localparam int TRIG = 20;
    localparam int CPC  = 10;
    localparam int BAUD = 8;
    localparam int TMO  = 15000;

    logic       clock = 1'b0;
    logic       reset;
    logic       mensurar;
    logic       echo;
    logic       trigger, saida_serial, pronto;
    logic [6:0] medida0, medida1, medida2, db_estado;

    int tests = 0;
    int fails = 0;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    typedef struct {
        int w;
        int dly;
        int exp_cm;
    } vec_t;

    vec_t vecs [9];

    exp4_trena_top #(
        .TRIG_CYC   (TRIG),
        .CYC_PER_CM (CPC),
        .BAUD_CYC   (BAUD)
`ifdef TIMEOUT_EN
        ,
        .TIMEOUT_CYC(TMO)
`endif
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .mensurar     (mensurar),
        .echo         (echo),
        .trigger      (trigger),
        .saida_serial (saida_serial),
        .medida0      (medida0),
        .medida1      (medida1),
        .medida2      (medida2),
        .pronto       (pronto),
        .db_estado    (db_estado)
    );

    always #10 clock = ~clock;

    // Trigger pulse monitor: counts rising edges and records the last width.
    int   trig_rises  = 0;
    int   trig_w      = 0;
    int   trig_last_w = 0;
    logic trig_prev   = 1'b0;
    always @(negedge clock) begin
        if (trigger === 1'b1 && trig_prev !== 1'b1) trig_rises++;
        if (trigger === 1'b1) begin
            trig_w++;
        end else if (trig_prev === 1'b1) begin
            trig_last_w = trig_w;
            trig_w      = 0;
        end
        trig_prev = trigger;
    end

    initial begin
        #5_000_000;
        $display("FAIL sim_timeout: time limit reached, got no finish required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic int model_cm(input int w);
        int cm;
        cm = w / CPC;
        if ((w % CPC) >= CPC / 2) cm = cm + 1;
        if (cm > 999) cm = 999;
        return cm;
    endfunction

    // Receive one 7O2 frame by sampling mid-bit.
    task automatic uart_rx(input int bound, output logic [6:0] ch, output bit ok);
        int n;
        logic [10:0] f;
        ch = '0;
        ok = 1'b0;
        n  = 0;
        while (saida_serial !== 1'b0 && n < bound) begin
            @(negedge clock);
            n++;
        end
        if (n >= bound) return;
        repeat (BAUD / 2) @(negedge clock);
        for (int b = 0; b < 11; b++) begin
            f[b] = saida_serial;
            if (b < 10) repeat (BAUD) @(negedge clock);
        end
        ch = f[7:1];
        ok = (f[0] == 1'b0) && (^f[8:1] == 1'b1) && f[9] && f[10];
    endtask

    task automatic request();
        @(negedge clock);
        mensurar = 1'b1;
        repeat (5) @(negedge clock);
        mensurar = 1'b0;
    endtask

    task automatic wait_trig_done(input int r0);
        int n;
        n = 0;
        while (!(trig_rises == r0 + 1 && trigger === 1'b0) && n < 1000) begin
            @(negedge clock);
            n++;
        end
        chk("trigger_done", 32'(n < 1000), 32'd1);
    endtask

    // One full measurement: request, echo of w clocks, 4 UART chars, final display.
    task automatic measure(input int w, input int dly, input int exp_cm, input bit glitch);
        int n, r0, bound;
        logic [6:0] ch;
        bit ok;
        logic [6:0] exp_ch [4];
        logic [6:0] got_ch [4];
        exp_ch[0] = 7'(48 + exp_cm / 100);
        exp_ch[1] = 7'(48 + (exp_cm / 10) % 10);
        exp_ch[2] = 7'(48 + exp_cm % 10);
        exp_ch[3] = 7'h23;
        r0 = trig_rises;
        request();
        if (glitch) begin
            chk("trigger_high_at_glitch", 32'(trigger), 32'd1);
            echo = 1'b1;
            repeat (3) @(negedge clock);
            echo = 1'b0;
        end
        wait_trig_done(r0);
        repeat (dly) @(negedge clock);
        if (w > 0) begin
            echo = 1'b1;
            repeat (w) @(negedge clock);
            echo = 1'b0;
        end
        bound = (w == 0) ? TMO + 500 : 500;
        for (int i = 0; i < 4; i++) begin
            uart_rx(bound, ch, ok);
            got_ch[i] = ch;
            chk("uart_frame", 32'(ok), 32'd1);
            chk("uart_char", 32'(ch), 32'(exp_ch[i]));
            bound = 500;
        end
        n = 0;
        while (pronto !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("pronto", 32'(pronto), 32'd1);
        chk("state_final", 32'(db_estado), 32'(seg_tab[15]));
        chk("medida2", 32'(medida2), 32'(seg_tab[exp_cm / 100]));
        chk("medida1", 32'(medida1), 32'(seg_tab[(exp_cm / 10) % 10]));
        chk("medida0", 32'(medida0), 32'(seg_tab[exp_cm % 10]));
        chk("trigger_width", 32'(trig_last_w), 32'(TRIG));
        chk("trigger_count", 32'(trig_rises - r0), 32'd1);
        $display("[TB] measure echo=%0d dly=%0d expect=%0d uart=%s%s%s%s",
                 w, dly, exp_cm, string'(got_ch[0]), string'(got_ch[1]),
                 string'(got_ch[2]), string'(got_ch[3]));
    endtask

    initial begin
        int r0, w, d;
        vecs[0] = '{w: 1000,  dly: 20, exp_cm: 100};
        vecs[1] = '{w: 753,   dly: 5,  exp_cm: 75};
        vecs[2] = '{w: 546,   dly: 0,  exp_cm: 55};
        vecs[3] = '{w: 4,     dly: 3,  exp_cm: 0};
        vecs[4] = '{w: 5,     dly: 3,  exp_cm: 1};
        vecs[5] = '{w: 9984,  dly: 2,  exp_cm: 998};
        vecs[6] = '{w: 9985,  dly: 2,  exp_cm: 999};
        vecs[7] = '{w: 9995,  dly: 1,  exp_cm: 999};
        vecs[8] = '{w: 10005, dly: 7,  exp_cm: 999};

        mensurar = 1'b0;
        echo     = 1'b0;
        reset    = 1'b1;
        #5 reset = 1'b0;
        repeat (100) @(negedge clock);
        reset = 1'b1;
        repeat (100) @(negedge clock);
        chk("idle_pronto", 32'(pronto), 32'd0);
        chk("idle_line", 32'(saida_serial), 32'd1);
        chk("idle_trigger", 32'(trigger), 32'd0);
        chk("idle_state", 32'(db_estado), 32'(seg_tab[0]));
        chk("idle_m0", 32'(medida0), 32'(seg_tab[0]));
        chk("idle_m1", 32'(medida1), 32'(seg_tab[0]));
        chk("idle_m2", 32'(medida2), 32'(seg_tab[0]));
        $display("[TB] reset/idle checked");

        for (int i = 0; i < 9; i++) begin
            measure(vecs[i].w, vecs[i].dly, vecs[i].exp_cm, 1'b0);
        end

        // Echo pulse entirely inside the trigger window must not count.
        measure(300, 4, 30, 1'b1);

        // Reset in MEDE aborts at once and clears the display.
        measure(1000, 3, 100, 1'b0);
        r0 = trig_rises;
        request();
        wait_trig_done(r0);
        repeat (300) @(negedge clock);
        chk("wait_echo_state", 32'(db_estado), 32'(seg_tab[3]));
        echo = 1'b1;
        repeat (50) @(negedge clock);
        chk("mede_state", 32'(db_estado), 32'(seg_tab[4]));
        #3 reset = 1'b0;
        #1;
        chk("abort_state", 32'(db_estado), 32'(seg_tab[0]));
        chk("abort_trigger", 32'(trigger), 32'd0);
        chk("abort_line", 32'(saida_serial), 32'd1);
        chk("abort_pronto", 32'(pronto), 32'd0);
        chk("abort_m0", 32'(medida0), 32'(seg_tab[0]));
        chk("abort_m1", 32'(medida1), 32'(seg_tab[0]));
        chk("abort_m2", 32'(medida2), 32'(seg_tab[0]));
        $display("[TB] reset during measurement checked");
        echo = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        repeat (5) @(negedge clock);
        measure(753, 6, 75, 1'b0);

        for (int i = 0; i < 5; i++) begin
            w = int'($urandom_range(1, 2000));
            d = int'($urandom_range(0, 30));
            measure(w, d, model_cm(w), 1'b0);
        end

`ifdef TIMEOUT_EN
        // No echo at all: watchdog forces 999.
        measure(0, 0, 999, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
